// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity mode codes and frame helpers.
// The receiver imports the same package, so both ends agree on these encodings.
package uart_pkg;

    localparam int unsigned STATE_W = 3;

    // Frame FSM state encoding.
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_START  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
    localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

    // ParityMode codes; 2'b11 is a second spelling of "no parity".
    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b01;
    localparam logic [1:0] PAR_ODD      = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    // True when the mode inserts a parity bit after the data bits.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Requested data bit count; 0 or anything wider than the data path means full width.
    function automatic int unsigned effective_nbits(input logic [7:0]  nbits,
                                                    input int unsigned data_w);
        int unsigned req;
        req = {24'd0, nbits};
        if ((req == 0) || (req > data_w)) begin
            return data_w;
        end
        return req;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Input word queue for the UART transmitter. Show-ahead: pop_data_o always
// presents the oldest word, so the consumer latches it on the popping edge.
module uart_tx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned    PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q,  count_d;
    logic              do_push, do_pop;

    assign full_o     = (count_q == DEPTH_C);
    assign empty_o    = (count_q == '0);
    assign do_pop     = pop_i && !empty_o;
    // A pop frees a slot on the same edge, so a full queue still takes a write alongside it.
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = mem_q[rd_ptr_q];

    // Next-state for the pointers and occupancy count.
    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Word storage.
    // NOTE: the storage array has no reset; a slot is only read after it was written, and the empty flag guards that.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and count registers; reset empties the queue and discards old words.
    // NOTE: sequential state is updated with non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: queued words are framed as start, 1..DATA_W
// data bits (LSB first), optional parity and one or two stop bits. Each bit
// lasts OVERSAMPLE pulses of the externally generated Tick enable.
module uart_tx_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Tick,
    input  logic [DATA_W-1:0] TxData,
    input  logic              TxValid,
    output logic              TxReady,
    input  logic [7:0]        NBits,
    input  logic [1:0]        ParityMode,
    input  logic              StopBits,
    output logic              Tx,
    output logic              Busy,
    output logic              TxDone
);

    import uart_pkg::*;

    localparam int unsigned       TICK_W    = $clog2(OVERSAMPLE);
    localparam int unsigned       BIT_W     = $clog2(DATA_W + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    logic [STATE_W-1:0] state_q,    state_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [BIT_W-1:0]   nbits_q,    nbits_d;
    logic [DATA_W-1:0]  shift_q,    shift_d;
    logic [1:0]         pmode_q,    pmode_d;
    logic               stop2_q,    stop2_d;
    logic               stop_cnt_q, stop_cnt_d;
    logic               parity_q,   parity_d;
    logic               tx_q,       tx_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;

    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              tick_adv, bit_end, frame_end;

    assign TxReady   = !fifo_full;
    assign fifo_push = TxValid && !fifo_full;

    // Ticks only advance the bit timer while a frame is on the line.
    assign tick_adv  = (state_q != ST_IDLE) && Tick;
    assign bit_end   = tick_adv && (tick_cnt_q == TICK_LAST);
    assign frame_end = bit_end && (state_q == ST_STOP) && (stop_cnt_q == stop2_q);
    // A word is taken either from idle or at the last stop edge, the latter giving gapless frames.
    assign fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || frame_end);

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (Clk),
        .rst_ni      (Rst_n),
        .push_i      (fifo_push),
        .push_data_i (TxData),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Frame sequencing: bit timing, data shifting, parity accumulation and frame loading.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        nbits_d    = nbits_q;
        shift_d    = shift_q;
        pmode_d    = pmode_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (bit_end) begin
            tick_cnt_d = '0;
            case (state_q)
                ST_START: begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
                ST_DATA: begin
                    parity_d = parity_q ^ shift_q[0];
                    shift_d  = shift_q >> 1;
                    if (bit_cnt_q == nbits_q - BIT_ONE) begin
                        if (parity_enabled(pmode_q)) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_q ^ shift_q[0] ^ (pmode_q == PAR_ODD);
                        end else begin
                            state_d    = ST_STOP;
                            stop_cnt_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                        tx_d      = shift_d[0];
                    end
                end
                ST_PARITY: begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b1;
                end
                ST_STOP: begin
                    if (stop_cnt_q != stop2_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            endcase
        end else if (tick_adv) begin
            tick_cnt_d = tick_cnt_q + TICK_ONE;
        end

        // Loading a word overrides the idle/stop outcome; config is frozen here for the whole frame.
        if (fifo_pop) begin
            state_d    = ST_START;
            shift_d    = fifo_rd_data;
            nbits_d    = BIT_W'(effective_nbits(NBits, DATA_W));
            pmode_d    = ParityMode;
            stop2_d    = StopBits;
            stop_cnt_d = 1'b0;
            parity_d   = 1'b0;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
        end
    end

    // Frame state registers; reset returns the line to idle-high at once, even mid-frame.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            nbits_q    <= '0;
            shift_q    <= '0;
            pmode_q    <= PAR_NONE;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            nbits_q    <= nbits_d;
            shift_q    <= shift_d;
            pmode_q    <= pmode_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Tx     = tx_q;
    assign Busy   = busy_q;
    assign TxDone = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param with OVERSAMPLE=16 and Tick every 4 clocks,
// so one bit period is 64 clocks. Every post-edge value of Tx/Busy/TxDone is
// logged by edge index and frames are checked against that log.
module tb_uart_tx_param;

    localparam int LOG_N = 32768;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] nbits;
    logic [1:0] pmode;
    logic       stop2;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int n_compared   = 0;
    int n_mismatched = 0;

    int   edge_n   = 0;
    int   done_cnt = 0;
    int   busy_cyc = 0;
    logic tx_log   [LOG_N];
    logic busy_log [LOG_N];
    logic done_log [LOG_N];

    logic [7:0] q_words [8];
    int         q_n;
    int         q_pushed;
    int         acc_edge [8];
    int         first_block;

    uart_tx_param #(
        .DATA_W     (8),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (4)
    ) dut (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .Tick       (tick),
        .TxData     (tx_data),
        .TxValid    (tx_valid),
        .TxReady    (tx_ready),
        .NBits      (nbits),
        .ParityMode (pmode),
        .StopBits   (stop2),
        .Tx         (tx),
        .Busy       (busy),
        .TxDone     (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge logger and baud tick source: ticks are sampled on edges whose index is a multiple of 4.
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (edge_n < LOG_N) begin
                tx_log[edge_n]   = tx;
                busy_log[edge_n] = busy;
                done_log[edge_n] = tx_done;
            end
            if (tx_done === 1'b1) done_cnt++;
            if (busy === 1'b1) busy_cyc++;
            edge_n++;
            tick = (edge_n % 4 == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_edge(input int target);
        while (edge_n <= target) step();
    endtask

    // Reference frame: start, data LSB first, optional parity, one or two stops.
    function automatic int build_frame(input logic [7:0] word, input logic [7:0] nb,
                                       input logic [1:0] pm, input logic two_stop,
                                       output logic [15:0] bits);
        int   n;
        int   neff;
        logic par;
        bits = '1;
        par  = 1'b0;
        neff = (nb == 8'd0 || nb > 8'd8) ? 8 : int'(nb);
        bits[0] = 1'b0;
        n = 1;
        for (int i = 0; i < neff; i++) begin
            bits[n] = word[i];
            par ^= word[i];
            n++;
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            bits[n] = par ^ (pm == 2'b10);
            n++;
        end
        bits[n] = 1'b1;
        n++;
        if (two_stop) begin
            bits[n] = 1'b1;
            n++;
        end
        return n;
    endfunction

    // Offers q_words[0..q_n-1] in order, starting so that the first accept lands on an edge = 3 mod 4.
    task automatic push_queue();
        int   i     = 0;
        int   guard = 0;
        logic rdy;
        first_block = -1;
        while (edge_n % 4 != 3) step();
        while (i < q_n && guard < 4000) begin
            tx_data  = q_words[i];
            tx_valid = 1'b1;
            rdy      = tx_ready;
            if (rdy) acc_edge[i] = edge_n;
            else if (first_block < 0) first_block = edge_n;
            step();
            guard++;
            if (rdy) i++;
        end
        tx_valid = 1'b0;
        q_pushed = i;
    endtask

    task automatic test_reset();
        #3;
        rst_n = 1'b0;
        #1;
        n_compared++; if (tx !== 1'b1) begin n_mismatched++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_compared++; if (tx_done !== 1'b0) begin n_mismatched++; $display("FAIL reset_done: got %b expected 0", tx_done); end
        n_compared++; if (tx_ready !== 1'b1) begin n_mismatched++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
        repeat (3) step();
        rst_n = 1'b1;
        repeat (20) step();
        n_compared++; if (busy !== 1'b0 || tx !== 1'b1) begin n_mismatched++; $display("FAIL idle_after_reset: busy %b tx %b expected busy 0 tx 1", busy, tx); end
    endtask

    task automatic test_basic_8n1();
        logic [15:0] eb;
        int len, p0, d0, b0;
        nbits = 8'd8; pmode = 2'b00; stop2 = 1'b0;
        q_words[0] = 8'hA5; q_n = 1;
        d0 = done_cnt; b0 = busy_cyc;
        push_queue();
        p0  = acc_edge[0] + 1;
        len = build_frame(8'hA5, 8'd8, 2'b00, 1'b0, eb);
        wait_edge(p0 + 64 * len + 4);
        for (int k = 0; k < len; k++) begin
            n_compared++;
            if (tx_log[p0 + 64*k] !== eb[k] || tx_log[p0 + 64*k + 63] !== eb[k]) begin
                n_mismatched++;
                $display("FAIL basic_bit%0d: got %b..%b expected %b for 64 clocks", k, tx_log[p0 + 64*k], tx_log[p0 + 64*k + 63], eb[k]);
            end
        end
        n_compared++; if (tx_log[p0 - 1] !== 1'b1) begin n_mismatched++; $display("FAIL basic_idle_line: got %b expected 1", tx_log[p0 - 1]); end
        n_compared++; if (busy_cyc - b0 !== 640) begin n_mismatched++; $display("FAIL basic_busy_len: got %0d expected 640", busy_cyc - b0); end
        n_compared++; if (done_cnt - d0 !== 1) begin n_mismatched++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
        n_compared++; if (done_log[p0 + 640] !== 1'b1) begin n_mismatched++; $display("FAIL basic_done_edge: got %b expected 1", done_log[p0 + 640]); end
        n_compared++; if (busy_log[p0 + 640] !== 1'b0 || tx_log[p0 + 640] !== 1'b1) begin n_mismatched++; $display("FAIL basic_end_state: busy %b tx %b expected busy 0 tx 1", busy_log[p0 + 640], tx_log[p0 + 640]); end
    endtask

    task automatic test_parity();
        logic [1:0]  pm_t  [3] = '{2'b01, 2'b10, 2'b01};
        logic        st_t  [3] = '{1'b0, 1'b0, 1'b1};
        logic        par_t [3] = '{1'b1, 1'b0, 1'b1};
        int          len_t [3] = '{11, 11, 12};
        logic [15:0] eb;
        int len, p0, d0;
        for (int v = 0; v < 3; v++) begin
            nbits = 8'd8; pmode = pm_t[v]; stop2 = st_t[v];
            q_words[0] = 8'h07; q_n = 1;
            d0 = done_cnt;
            push_queue();
            p0  = acc_edge[0] + 1;
            len = build_frame(8'h07, 8'd8, pm_t[v], st_t[v], eb);
            wait_edge(p0 + 64 * len_t[v] + 4);
            for (int k = 0; k < len; k++) begin
                n_compared++;
                if (tx_log[p0 + 64*k] !== eb[k] || tx_log[p0 + 64*k + 63] !== eb[k]) begin
                    n_mismatched++;
                    $display("FAIL parity%0d_bit%0d: got %b..%b expected %b", v, k, tx_log[p0 + 64*k], tx_log[p0 + 64*k + 63], eb[k]);
                end
            end
            n_compared++; if (tx_log[p0 + 64*9 + 32] !== par_t[v]) begin n_mismatched++; $display("FAIL parity%0d_value: got %b expected %b", v, tx_log[p0 + 64*9 + 32], par_t[v]); end
            n_compared++;
            if (busy_log[p0 + 64*len_t[v] - 1] !== 1'b1 || busy_log[p0 + 64*len_t[v]] !== 1'b0) begin
                n_mismatched++;
                $display("FAIL parity%0d_frame_len: busy %b,%b at end expected 1,0 for %0d bits", v, busy_log[p0 + 64*len_t[v] - 1], busy_log[p0 + 64*len_t[v]], len_t[v]);
            end
            n_compared++; if (done_cnt - d0 !== 1) begin n_mismatched++; $display("FAIL parity%0d_done: got %0d expected 1", v, done_cnt - d0); end
        end
        pmode = 2'b00; stop2 = 1'b0;
    endtask

    task automatic test_nbits();
        logic [7:0]  w_t   [3] = '{8'h1F, 8'h3C, 8'h81};
        logic [7:0]  nb_t  [3] = '{8'd5, 8'd0, 8'd200};
        int          len_t [3] = '{7, 10, 10};
        logic [15:0] eb;
        int len, p0;
        for (int v = 0; v < 3; v++) begin
            nbits = nb_t[v]; pmode = 2'b00; stop2 = 1'b0;
            q_words[0] = w_t[v]; q_n = 1;
            push_queue();
            p0  = acc_edge[0] + 1;
            len = build_frame(w_t[v], nb_t[v], 2'b00, 1'b0, eb);
            wait_edge(p0 + 64 * len_t[v] + 4);
            for (int k = 0; k < len; k++) begin
                n_compared++;
                if (tx_log[p0 + 64*k] !== eb[k] || tx_log[p0 + 64*k + 63] !== eb[k]) begin
                    n_mismatched++;
                    $display("FAIL nbits%0d_bit%0d: got %b..%b expected %b", v, k, tx_log[p0 + 64*k], tx_log[p0 + 64*k + 63], eb[k]);
                end
            end
            n_compared++;
            if (busy_log[p0 + 64*len_t[v] - 1] !== 1'b1 || busy_log[p0 + 64*len_t[v]] !== 1'b0) begin
                n_mismatched++;
                $display("FAIL nbits%0d_frame_len: busy %b,%b at end expected 1,0 for %0d bits", v, busy_log[p0 + 64*len_t[v] - 1], busy_log[p0 + 64*len_t[v]], len_t[v]);
            end
        end
        nbits = 8'd8;
    endtask

    task automatic test_back_to_back();
        logic [15:0] eb;
        int len, p0, d0, b0;
        nbits = 8'd8; pmode = 2'b00; stop2 = 1'b0;
        for (int i = 0; i < 6; i++) q_words[i] = 8'(8'h11 * (i + 1));
        q_n = 6;
        d0 = done_cnt; b0 = busy_cyc;
        push_queue();
        p0 = acc_edge[0] + 1;
        n_compared++; if (q_pushed !== 6) begin n_mismatched++; $display("FAIL b2b_all_accepted: got %0d expected 6", q_pushed); end
        n_compared++; if (first_block !== p0 + 4) begin n_mismatched++; $display("FAIL b2b_ready_fall: got edge %0d expected %0d", first_block, p0 + 4); end
        for (int i = 1; i < 5; i++) begin
            n_compared++; if (acc_edge[i] !== p0 + i - 1) begin n_mismatched++; $display("FAIL b2b_accept%0d: got edge %0d expected %0d", i, acc_edge[i], p0 + i - 1); end
        end
        n_compared++; if (acc_edge[5] !== p0 + 641) begin n_mismatched++; $display("FAIL b2b_held_word: got edge %0d expected %0d", acc_edge[5], p0 + 641); end
        wait_edge(p0 + 6 * 640 + 4);
        for (int f = 0; f < 6; f++) begin
            len = build_frame(q_words[f], 8'd8, 2'b00, 1'b0, eb);
            for (int k = 0; k < len; k++) begin
                n_compared++;
                if (tx_log[p0 + 640*f + 64*k] !== eb[k] || tx_log[p0 + 640*f + 64*k + 63] !== eb[k]) begin
                    n_mismatched++;
                    $display("FAIL b2b_f%0d_bit%0d: got %b..%b expected %b", f, k, tx_log[p0 + 640*f + 64*k], tx_log[p0 + 640*f + 64*k + 63], eb[k]);
                end
            end
        end
        n_compared++; if (busy_cyc - b0 !== 3840) begin n_mismatched++; $display("FAIL b2b_busy_len: got %0d expected 3840", busy_cyc - b0); end
        n_compared++; if (done_cnt - d0 !== 6) begin n_mismatched++; $display("FAIL b2b_done_count: got %0d expected 6", done_cnt - d0); end
    endtask

    task automatic test_config_change();
        logic [15:0] eb;
        int len, p0, p1;
        nbits = 8'd8; pmode = 2'b00; stop2 = 1'b0;
        q_words[0] = 8'hC3; q_words[1] = 8'h5A; q_n = 2;
        push_queue();
        p0 = acc_edge[0] + 1;
        p1 = p0 + 640;
        wait_edge(p0 + 200);
        nbits = 8'd7;
        wait_edge(p1 + 576 + 4);
        len = build_frame(8'hC3, 8'd8, 2'b00, 1'b0, eb);
        for (int k = 0; k < len; k++) begin
            n_compared++;
            if (tx_log[p0 + 64*k + 32] !== eb[k]) begin n_mismatched++; $display("FAIL cfg_f0_bit%0d: got %b expected %b", k, tx_log[p0 + 64*k + 32], eb[k]); end
        end
        len = build_frame(8'h5A, 8'd7, 2'b00, 1'b0, eb);
        for (int k = 0; k < len; k++) begin
            n_compared++;
            if (tx_log[p1 + 64*k + 32] !== eb[k]) begin n_mismatched++; $display("FAIL cfg_f1_bit%0d: got %b expected %b", k, tx_log[p1 + 64*k + 32], eb[k]); end
        end
        n_compared++;
        if (busy_log[p1 + 575] !== 1'b1 || busy_log[p1 + 576] !== 1'b0) begin
            n_mismatched++;
            $display("FAIL cfg_f1_len: busy %b,%b at end expected 1,0", busy_log[p1 + 575], busy_log[p1 + 576]);
        end
        nbits = 8'd8;
    endtask

    task automatic test_midframe_reset();
        int p0, d0, b0, rel, bad;
        nbits = 8'd8; pmode = 2'b00; stop2 = 1'b0;
        q_words[0] = 8'h96; q_words[1] = 8'h11; q_words[2] = 8'h22; q_n = 3;
        push_queue();
        p0 = acc_edge[0] + 1;
        wait_edge(p0 + 256 + 20);
        n_compared++; if (tx_log[p0 + 256 + 10] !== 1'b0) begin n_mismatched++; $display("FAIL rst_bit3_before: got %b expected 0", tx_log[p0 + 256 + 10]); end
        d0 = done_cnt;
        #1;
        rst_n = 1'b0;
        #1;
        n_compared++; if (tx !== 1'b1) begin n_mismatched++; $display("FAIL rst_mid_tx: got %b expected 1", tx); end
        n_compared++; if (tx_ready !== 1'b1) begin n_mismatched++; $display("FAIL rst_mid_ready: got %b expected 1", tx_ready); end
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        repeat (3) step();
        rst_n = 1'b1;
        b0  = busy_cyc;
        rel = edge_n;
        wait_edge(rel + 1500);
        bad = 0;
        for (int i = rel; i < rel + 1500; i++) if (tx_log[i] !== 1'b1) bad++;
        n_compared++; if (bad !== 0) begin n_mismatched++; $display("FAIL rst_line_idle: got %0d non-idle edges expected 0", bad); end
        n_compared++; if (busy_cyc !== b0) begin n_mismatched++; $display("FAIL rst_no_frame: got %0d busy edges expected 0", busy_cyc - b0); end
        n_compared++; if (done_cnt !== d0) begin n_mismatched++; $display("FAIL rst_no_done: got %0d pulses expected 0", done_cnt - d0); end
    endtask

    initial begin
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        nbits    = 8'd8;
        pmode    = 2'b00;
        stop2    = 1'b0;
        q_n      = 0;
        q_pushed = 0;

        test_reset();
        test_basic_8n1();
        test_parity();
        test_nbits();
        test_back_to_back();
        test_config_change();
        test_midframe_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
